// File: rtl/axi_req_flit_packer.sv
`default_nettype none
// ============================================================================
//  Module      : axi_req_flit_packer
//  Description : Packs a flit-serial HMC request stream into FPW-wide
//                AXI-Stream beats (TVALID/TDATA/TUSER) with idle flush and
//                header/tail sequencing check.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_req_flit_packer #(
    parameter int FPW        = 4,
    parameter int IDLE_FLUSH = 4
) (
    input  logic                clk,
    input  logic                res,
    input  logic                flit_valid,
    output logic                flit_ready,
    input  logic [127:0]        flit_data,
    input  logic                flit_hdr,
    input  logic                flit_tail,
    output logic                TVALID,
    input  logic                TREADY,
    output logic [FPW*128-1:0]  TDATA,
    output logic [FPW*16-1:0]   TUSER,
    output logic                proto_err
);

    localparam int c_dwidth = FPW * 128;
    localparam int c_uwidth = FPW * 16;
    localparam int c_cnt_w  = $clog2(FPW + 1);
    localparam int c_idle_w = $clog2(IDLE_FLUSH + 1);
    localparam logic [c_cnt_w-1:0]  c_full  = c_cnt_w'(FPW);
    localparam logic [c_idle_w-1:0] c_flush = c_idle_w'(IDLE_FLUSH);

    // assembly buffer
    logic [127:0]         r_slot_data [FPW];
    logic [FPW-1:0]       r_slot_hdr;
    logic [FPW-1:0]       r_slot_tail;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_idle_w-1:0]  r_idle;

    // output beat register
    logic                 r_tvalid;
    logic [c_dwidth-1:0]  r_tdata;
    logic [c_uwidth-1:0]  r_tuser;

    // packet tracker
    logic                 r_in_pkt;
    logic                 r_proto_err;

    logic                 w_accept;
    logic                 w_launch;
    logic [FPW-1:0]       w_slot_vld;
    logic [FPW-1:0]       w_slot_wr;
    logic [c_dwidth-1:0]  w_beat_data;
    logic [c_uwidth-1:0]  w_beat_user;

    assign flit_ready = !res && (r_count < c_full);
    assign w_accept   = flit_valid && flit_ready;

    // A beat leaves when the buffer is full or has sat idle long enough, and
    // the output register is empty or being drained this cycle.
    assign w_launch = ((r_count == c_full) || (r_idle == c_flush)) &&
                      (!r_tvalid || TREADY);

    for (genvar gi = 0; gi < FPW; gi++) begin : g_slot
        assign w_slot_vld[gi] = (r_count > c_cnt_w'(gi));
        if (gi == 0) begin : g_first
            // a flit arriving with a flush launch starts the emptied buffer
            assign w_slot_wr[gi] = w_accept && (w_launch || (r_count == '0));
        end else begin : g_rest
            assign w_slot_wr[gi] = w_accept && !w_launch &&
                                   (r_count == c_cnt_w'(gi));
        end
        assign w_beat_data[128*gi +: 128] = w_slot_vld[gi] ? r_slot_data[gi] : '0;
    end

    assign w_beat_user = {{(c_uwidth - 3*FPW){1'b0}},
                          r_slot_tail & w_slot_vld,
                          r_slot_hdr  & w_slot_vld,
                          w_slot_vld};

    // slot storage; stale contents are masked by the fill count at launch
    always_ff @(posedge clk) begin
        for (int i = 0; i < FPW; i++) begin
            if (w_slot_wr[i]) begin
                r_slot_data[i] <= flit_data;
                r_slot_hdr[i]  <= flit_hdr;
                r_slot_tail[i] <= flit_tail;
            end
        end
    end

    // fill count and idle-flush timer
    always_ff @(posedge clk) begin
        if (res) begin
            r_count <= '0;
            r_idle  <= '0;
        end else begin
            if (w_launch) begin
                r_count <= w_accept ? c_cnt_w'(1) : '0;
            end else if (w_accept) begin
                r_count <= r_count + 1'b1;
            end

            if (w_accept || (r_count == '0) || w_launch) begin
                r_idle <= '0;
            end else if (r_idle != c_flush) begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    // output register: hold under backpressure, reload on launch
    always_ff @(posedge clk) begin
        if (res) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tuser  <= '0;
        end else if (w_launch) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_beat_data;
            r_tuser  <= w_beat_user;
        end else if (TREADY) begin
            r_tvalid <= 1'b0;
        end
    end

    // header/tail sequencing check; flits are forwarded regardless
    always_ff @(posedge clk) begin
        if (res) begin
            r_in_pkt    <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= w_accept && (flit_hdr == r_in_pkt);
            if (w_accept) begin
                r_in_pkt <= (r_in_pkt || flit_hdr) && !flit_tail;
            end
        end
    end

    assign TVALID    = r_tvalid;
    assign TDATA     = r_tdata;
    assign TUSER     = r_tuser;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_req_flit_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_axi_req_flit_packer
//  Description : Self-checking bench for axi_req_flit_packer: directed
//                scenarios plus randomized traffic against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_req_flit_packer;

    localparam int FPW        = 4;
    localparam int IDLE_FLUSH = 4;
    localparam int DW         = FPW * 128;
    localparam int UW         = FPW * 16;

    logic           clk = 1'b0;
    logic           res;
    logic           flit_valid;
    logic           flit_ready;
    logic [127:0]   flit_data;
    logic           flit_hdr;
    logic           flit_tail;
    logic           TVALID;
    logic           TREADY;
    logic [DW-1:0]  TDATA;
    logic [UW-1:0]  TUSER;
    logic           proto_err;

    always #5 clk = ~clk;

    axi_req_flit_packer #(.FPW(FPW), .IDLE_FLUSH(IDLE_FLUSH)) dut (
        .clk        (clk),
        .res        (res),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .flit_data  (flit_data),
        .flit_hdr   (flit_hdr),
        .flit_tail  (flit_tail),
        .TVALID     (TVALID),
        .TREADY     (TREADY),
        .TDATA      (TDATA),
        .TUSER      (TUSER),
        .proto_err  (proto_err)
    );

    typedef struct {
        logic [127:0] data;
        logic         hdr;
        logic         tail;
    } flit_t;

    // reference model: buffered flits as a queue plus output-beat state
    flit_t          fq[$];
    int             m_idle;
    bit             m_tv;
    logic [DW-1:0]  m_td;
    logic [UW-1:0]  m_tu;
    bit             m_in_pkt;
    bit             m_perr;

    logic [DW+UW-1:0] dut_beats[$];   // {TUSER, TDATA} of each handshaken beat
    int n_vec = 0;
    int n_err = 0;

    task automatic drive(input bit v, input int d, input bit h, input bit t);
        flit_valid = v;
        flit_data  = 128'(d);
        flit_hdr   = h;
        flit_tail  = t;
    endtask

    // one clock: advance the model from the pre-edge inputs, record DUT beats
    task automatic step(output bit acc);
        bit            launch;
        int            sz;
        flit_t         f;
        logic [DW-1:0] nd;
        logic [UW-1:0] nu;
        sz     = fq.size();
        f.data = flit_data;
        f.hdr  = flit_hdr;
        f.tail = flit_tail;
        acc    = !res && flit_valid && (sz < FPW);
        launch = (sz == FPW || m_idle == IDLE_FLUSH) && (!m_tv || TREADY);
        nd = '0;
        nu = '0;
        for (int i = 0; i < sz; i++) begin
            nd[128*i +: 128] = fq[i].data;
            nu[i]            = 1'b1;
            nu[FPW+i]        = fq[i].hdr;
            nu[2*FPW+i]      = fq[i].tail;
        end
        if (TVALID === 1'b1 && TREADY === 1'b1) dut_beats.push_back({TUSER, TDATA});
        @(posedge clk);
        if (res) begin
            fq.delete();
            m_idle = 0; m_tv = 0; m_td = '0; m_tu = '0; m_in_pkt = 0; m_perr = 0;
        end else begin
            m_perr = acc && (f.hdr == m_in_pkt);
            if (acc) m_in_pkt = (m_in_pkt || f.hdr) && !f.tail;
            if (acc || sz == 0 || launch) m_idle = 0;
            else if (m_idle < IDLE_FLUSH) m_idle++;
            if (launch) begin
                m_tv = 1; m_td = nd; m_tu = nu;
                fq.delete();
            end else if (TREADY) begin
                m_tv = 0;
            end
            if (acc) fq.push_back(f);
        end
        #1;
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        drive(0, 0, 0, 0);
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic test_reset();
        bit acc;
        res = 1; TREADY = 1;
        drive(0, 0, 0, 0);
        step(acc);
        step(acc);
        n_vec++; if (TVALID !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b exp=0", TVALID); end
        n_vec++; if (TDATA !== '0) begin n_err++; $display("FAIL reset_tdata got=%h exp=0", TDATA); end
        n_vec++; if (TUSER !== '0) begin n_err++; $display("FAIL reset_tuser got=%h exp=0", TUSER); end
        n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_perr got=%b exp=0", proto_err); end
        n_vec++; if (flit_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_in_res got=%b exp=0", flit_ready); end
        res = 0;
        #1;
        n_vec++; if (flit_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after got=%b exp=1", flit_ready); end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int k = 0;
        logic [DW-1:0] exp_d;
        idle_cycles(2);
        dut_beats.delete();
        TREADY = 1;
        for (int c = 0; c < 40 && (k < 8 || dut_beats.size() < 2); c++) begin
            drive(k < 8, k, k == 0, k == 7);
            step(acc);
            if (acc) k++;
            n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL b2b_perr cyc=%0d got=%b exp=0", c, proto_err); end
            n_vec++; if (TVALID !== m_tv) begin n_err++; $display("FAIL b2b_tvalid cyc=%0d got=%b exp=%b", c, TVALID, m_tv); end
        end
        drive(0, 0, 0, 0);
        n_vec++;
        if (dut_beats.size() != 2) begin
            n_err++; $display("FAIL b2b_beats got=%0d exp=2", dut_beats.size());
        end else begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < FPW; i++) exp_d[128*i +: 128] = 128'(4*b + i);
                n_vec++;
                if (dut_beats[b][DW-1:0] !== exp_d) begin
                    n_err++; $display("FAIL b2b_data%0d got=%h exp=%h", b, dut_beats[b][DW-1:0], exp_d);
                end
                n_vec++;
                if (dut_beats[b][DW+UW-1:DW] !== ((b == 0) ? 64'h01F : 64'h80F)) begin
                    n_err++; $display("FAIL b2b_user%0d got=%h exp=%h", b, dut_beats[b][DW+UW-1:DW], (b == 0) ? 64'h01F : 64'h80F);
                end
            end
        end
    endtask

    task automatic test_partial();
        bit acc;
        int k = 0;
        int n = 0;
        idle_cycles(3);
        TREADY = 1;
        for (int c = 0; c < 20 && k < 3; c++) begin
            drive(1, 16 + k, k == 0, k == 2);
            step(acc);
            if (acc) k++;
        end
        drive(0, 0, 0, 0);
        while (TVALID !== 1'b1 && n < 20) begin
            step(acc);
            n++;
        end
        n_vec++; if (n != IDLE_FLUSH + 1) begin n_err++; $display("FAIL partial_latency got=%0d exp=%0d", n, IDLE_FLUSH + 1); end
        n_vec++; if (TUSER !== 64'h417) begin n_err++; $display("FAIL partial_user got=%h exp=%h", TUSER, 64'h417); end
        n_vec++; if (TDATA[511:384] !== 128'd0) begin n_err++; $display("FAIL partial_slot3 got=%h exp=0", TDATA[511:384]); end
        n_vec++;
        if (TDATA[383:0] !== {128'd18, 128'd17, 128'd16}) begin
            n_err++; $display("FAIL partial_data got=%h exp=%h", TDATA[383:0], {128'd18, 128'd17, 128'd16});
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        int k = 0;
        bit seen = 0;
        logic [DW+UW-1:0] held;
        logic [DW-1:0] exp_d;
        idle_cycles(3);
        TREADY = 0;
        for (int c = 0; c < 12; c++) begin
            drive(k < 8, 64 + k, k == 0, k == 7);
            step(acc);
            if (acc) k++;
            if (seen) begin
                n_vec++;
                if ({TUSER, TDATA} !== held || TVALID !== 1'b1) begin
                    n_err++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, TUSER, held[DW+UW-1:DW]);
                end
            end else if (TVALID === 1'b1) begin
                held = {TUSER, TDATA};
                seen = 1;
            end
        end
        drive(0, 0, 0, 0);
        n_vec++; if (k != 8) begin n_err++; $display("FAIL bp_accepts got=%0d exp=8", k); end
        n_vec++; if (flit_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready got=%b exp=0", flit_ready); end
        dut_beats.delete();
        TREADY = 1;
        for (int c = 0; c < 10; c++) step(acc);
        n_vec++;
        if (dut_beats.size() != 2) begin
            n_err++; $display("FAIL bp_beats got=%0d exp=2", dut_beats.size());
        end else begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < FPW; i++) exp_d[128*i +: 128] = 128'(64 + 4*b + i);
                n_vec++;
                if (dut_beats[b][DW-1:0] !== exp_d) begin
                    n_err++; $display("FAIL bp_data%0d got=%h exp=%h", b, dut_beats[b][DW-1:0], exp_d);
                end
                n_vec++;
                if (dut_beats[b][DW+UW-1:DW] !== ((b == 0) ? 64'h01F : 64'h80F)) begin
                    n_err++; $display("FAIL bp_user%0d got=%h", b, dut_beats[b][DW+UW-1:DW]);
                end
            end
        end
    endtask

    task automatic test_single();
        bit acc;
        idle_cycles(2);
        dut_beats.delete();
        TREADY = 1;
        drive(1, 'hABCD, 1, 1);
        step(acc);
        n_vec++; if (!acc) begin n_err++; $display("FAIL single_accept got=0 exp=1"); end
        drive(0, 0, 0, 0);
        for (int c = 0; c < 20 && dut_beats.size() == 0; c++) begin
            step(acc);
            n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL single_perr cyc=%0d got=%b exp=0", c, proto_err); end
        end
        n_vec++;
        if (dut_beats.size() != 1) begin
            n_err++; $display("FAIL single_beats got=%0d exp=1", dut_beats.size());
        end else begin
            n_vec++;
            if (dut_beats[0][DW+UW-1:DW] !== 64'h111) begin
                n_err++; $display("FAIL single_user got=%h exp=%h", dut_beats[0][DW+UW-1:DW], 64'h111);
            end
            n_vec++;
            if (dut_beats[0][DW-1:0] !== DW'(128'hABCD)) begin
                n_err++; $display("FAIL single_data got=%h exp=abcd", dut_beats[0][DW-1:0]);
            end
        end
    endtask

    task automatic test_proto_err();
        bit acc;
        idle_cycles(2);
        dut_beats.delete();
        TREADY = 1;
        drive(1, 'hA1, 1, 0);
        step(acc);
        n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL perr_first got=%b exp=0", proto_err); end
        drive(1, 'hB2, 1, 1);
        step(acc);
        n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL perr_second got=%b exp=1", proto_err); end
        drive(0, 0, 0, 0);
        step(acc);
        n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL perr_pulse got=%b exp=0", proto_err); end
        for (int c = 0; c < 20 && dut_beats.size() == 0; c++) step(acc);
        n_vec++;
        if (dut_beats.size() != 1) begin
            n_err++; $display("FAIL perr_beats got=%0d exp=1", dut_beats.size());
        end else begin
            n_vec++;
            if (dut_beats[0] !== {64'h233, 128'd0, 128'd0, 128'hB2, 128'hA1}) begin
                n_err++; $display("FAIL perr_beat got=%h exp=233", dut_beats[0][DW+UW-1:DW]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit acc;
        int k = 0;
        logic [DW-1:0] exp_d;
        idle_cycles(2);
        TREADY = 0;
        for (int c = 0; c < 20 && k < 6; c++) begin
            drive(1, (k < 4) ? 200 + k : 300 + k, k == 0 || k == 4, k == 3);
            step(acc);
            if (acc) k++;
        end
        drive(0, 0, 0, 0);
        n_vec++; if (TVALID !== 1'b1 || k != 6) begin n_err++; $display("FAIL mid_setup tvalid=%b accepts=%0d exp=1/6", TVALID, k); end
        res = 1;
        step(acc);
        res = 0;
        #1;
        n_vec++; if (TVALID !== 1'b0) begin n_err++; $display("FAIL mid_tvalid got=%b exp=0", TVALID); end
        n_vec++; if (flit_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got=%b exp=1", flit_ready); end
        TREADY = 1;
        dut_beats.delete();
        for (int c = 0; c < 8; c++) step(acc);
        n_vec++; if (dut_beats.size() != 0) begin n_err++; $display("FAIL mid_stale got=%0d exp=0", dut_beats.size()); end
        k = 0;
        for (int c = 0; c < 30 && dut_beats.size() == 0; c++) begin
            drive(k < 4, 400 + k, k == 0, k == 3);
            step(acc);
            if (acc) k++;
            n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL mid_perr cyc=%0d got=%b exp=0", c, proto_err); end
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < FPW; i++) exp_d[128*i +: 128] = 128'(400 + i);
        n_vec++;
        if (dut_beats.size() != 1 || dut_beats[0] !== {64'h81F, exp_d}) begin
            n_err++; $display("FAIL mid_clean beats=%0d user=%h exp=81f", dut_beats.size(),
                              (dut_beats.size() > 0) ? dut_beats[0][DW+UW-1:DW] : '0);
        end
    endtask

    task automatic test_random();
        bit acc;
        bit gen_in_pkt = 0;
        flit_t p;
        p.data = 128'({$urandom, $urandom, $urandom, $urandom});
        p.hdr  = 1; p.tail = 0;
        for (int c = 0; c < 800; c++) begin
            TREADY = ($urandom_range(0, 9) < 7);
            drive(($urandom_range(0, 9) < (((c / 60) % 2 == 0) ? 8 : 2)), 0, p.hdr, p.tail);
            flit_data = p.data;
            step(acc);
            if (acc) begin
                gen_in_pkt = (gen_in_pkt || p.hdr) && !p.tail;
                p.data = 128'({$urandom, $urandom, $urandom, $urandom});
                if ($urandom_range(0, 19) == 0) begin
                    p.hdr = 1'($urandom); p.tail = 1'($urandom);
                end else begin
                    p.hdr = !gen_in_pkt; p.tail = ($urandom_range(0, 2) == 0);
                end
            end
            n_vec++; if (flit_ready !== (fq.size() < FPW)) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, flit_ready, fq.size() < FPW); end
            n_vec++; if (TVALID !== m_tv) begin n_err++; $display("FAIL rnd_tvalid cyc=%0d got=%b exp=%b", c, TVALID, m_tv); end
            n_vec++; if (proto_err !== m_perr) begin n_err++; $display("FAIL rnd_perr cyc=%0d got=%b exp=%b", c, proto_err, m_perr); end
            if (m_tv) begin
                n_vec++; if (TUSER !== m_tu) begin n_err++; $display("FAIL rnd_user cyc=%0d got=%h exp=%h", c, TUSER, m_tu); end
                n_vec++; if (TDATA !== m_td) begin n_err++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, TDATA, m_td); end
            end
        end
        drive(0, 0, 0, 0);
        TREADY = 1;
    endtask

    initial begin
        res = 1; TREADY = 1;
        drive(0, 0, 0, 0);
        m_idle = 0; m_tv = 0; m_td = '0; m_tu = '0; m_in_pkt = 0; m_perr = 0;
        test_reset();
        test_back_to_back();
        test_partial();
        test_backpressure();
        test_single();
        test_proto_err();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_req_flit_packer.md
# axi_req_flit_packer

Packs a flit-serial stream of HMC request packets into the FPW-wide AXI-Stream request interface feeding the HMC controller. It drives TVALID/TDATA/TUSER and obeys TREADY. TUSER carries the per-slot valid, header and tail flags. It is the transmitting end of the request AXI link: the source the controller's request port consumes, and the model the request agent driver is checked against.

## Interface
- FPW, 4, flits per AXI beat; DWIDTH = FPW*128, NUM_DATA_BYTES = FPW*16
- IDLE_FLUSH, 4, consecutive idle cycles before a partial beat is flushed (≥1)
- clk  in  1  clock; all logic on rising edge
- res  in  1  reset; synchronous, active-high
- flit_valid  in  1  input flit present
- flit_ready  out  1  input flit accepted when flit_valid && flit_ready
- flit_data  in  128  one 128-bit flit
- flit_hdr  in  1  flit is first flit of a packet
- flit_tail  in  1  flit is last flit of a packet (may coincide with flit_hdr)
- TVALID  out  1  beat valid
- TREADY  in  1  downstream accepts beat when TVALID && TREADY
- TDATA  out  FPW*128  slot i = TDATA[128*i+127:128*i]; slot 0 = oldest flit
- TUSER  out  FPW*16  [FPW-1:0] valid, [2FPW-1:FPW] hdr, [3FPW-1:2FPW] tail, remaining bits 0
- proto_err  out  1  one-cycle pulse on header/tail sequencing violation

## Operation
- Assembly buffer: FPW slots plus count (0..FPW), hdr/tail/valid bit per slot. An accepted flit is written to slot[count] and count increments.
- flit_ready = !res && (count < FPW).
- Idle counter: cleared on any accepted flit or when count==0. Otherwise it increments while count>0, saturating at IDLE_FLUSH.
- Launch condition: (count==FPW || idle_cnt==IDLE_FLUSH) && (!TVALID || TREADY).
  - On launch, buffer slots are copied into the output register and TVALID is set.
  - Valid bits = slots 0..count-1. Unfilled slots have data 0 and flags 0.
  - count and idle_cnt clear.
- A flit accepted in the launch cycle is impossible when count==FPW (ready is low). When launch is due to flush (count<FPW), a flit accepted that cycle goes to slot 0 of the emptied buffer, not into the launching beat.
- Output register: holds TDATA/TUSER stable while TVALID && !TREADY. It clears TVALID on a handshake with no launch, and reloads on a same-cycle handshake plus launch.
- Packet tracker (in_pkt flag, reset 0). Evaluated per accepted flit:
  - hdr while in_pkt → proto_err.
  - !hdr while !in_pkt → proto_err.
  - in_pkt next = (in_pkt || hdr) && !tail.
  - The flit is always forwarded unchanged. Errors do not block traffic.
- Flags are not reordered. Packets may span beats. No packet-alignment padding.

## Timing
- Reset (res high at an edge) makes TVALID=0, TDATA=0, TUSER=0, proto_err=0, count=0, idle_cnt=0, in_pkt=0. Buffered and in-flight flits are discarded.
- Full-beat latency: the FPW-th flit is accepted at edge N; the beat is TVALID at edge N+1 if the output register is free.
- Sustained throughput: FPW flits per FPW+1 cycles (one ready-low cycle per beat).
- Partial-beat latency: last flit accepted at edge N; TVALID at edge N+IDLE_FLUSH+1 if the output register is free.
- Backpressure: with TVALID high and TREADY low, at most one further beat assembles. flit_ready stays low once count==FPW until launch.
- proto_err is registered and asserts the cycle after the offending flit is accepted.

## Test plan
- FPW=4, TREADY=1; 8-flit packet back-to-back (data = index) → two beats.
  - Beat 0: TUSER valid=4'hF, hdr=4'b0001, tail=0, slot i = i.
  - Beat 1: valid=4'hF, hdr=0, tail=4'b1000, slot i = 4+i.
  - No proto_err.
- 3-flit packet, then flit_valid low → beat TVALID exactly 5 edges after the last accept.
  - valid=4'b0111, hdr=4'b0001, tail=4'b0100, TDATA[511:384]=0.
- TREADY=0 for 12 cycles while 8 flits are offered.
  - Beat 0 held stable, beat 1 assembled, flit_ready low after the 8th accept.
  - On TREADY=1, beats 0 then 1 are delivered in order with no loss.
- Single flit with hdr=tail=1, then idle → beat with valid=4'b0001, hdr=4'b0001, tail=4'b0001, no proto_err.
- Header flit, then a second header flit with no tail in between → proto_err high for exactly one cycle after the second accept. Both flits appear in the beat.
- 2 flits buffered and a prior beat pending (TVALID=1, TREADY=0); assert res for one cycle.
  - Next cycle: TVALID=0, flit_ready=1.
  - No stale beat emitted.
  - A following 4-flit packet produces a clean valid=4'hF beat.
